md_sequencer: RTL

- Multiply/divide sequencer owning the HI/LO register pair.
- Sits in the E stage of the 5-stage pipeline and accepts mult/multu/div/divu/mthi/mtlo operations.
- Models multi-cycle latency with a down-counter and drives md_stall to the stall unit, which freezes D-stage mf*/md/mt*/shl instructions while it is high.
- Also supplies the HI/LO read value for mfhi/mflo.

---
 rtl/md_sequencer_pkg.sv | 32 +++
 rtl/md_arith.sv | 55 +++++
 rtl/md_sequencer.sv | 86 ++++++++
 3 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared multiply/divide op codes, HI/LO select codes and default latencies.
// Imported by the sequencer, its arithmetic unit and E-stage decode.
package md_sequencer_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic MD_SEL_LO = 1'b0;
  localparam logic MD_SEL_HI = 1'b1;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic logic md_is_start(
    input logic [2:0] op
  );
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(
    input logic [2:0] op
  );
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath for the latched md operation.
// Signed divide works on magnitudes so MIN/-1 needs no special case.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_by_zero
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] b_nz;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] mq;
  logic [31:0] mr;
  logic [31:0] uq;
  logic [31:0] ur;

  // low 64 bits of the sign-extended product equal the signed product
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'd0, a} * {32'd0, b};

  assign b_nz = (b == 32'd0) ? 32'd1 : b;
  assign ua   = a[31] ? (~a + 32'd1) : a;
  assign ub   = b_nz[31] ? (~b_nz + 32'd1) : b_nz;
  assign mq   = ua / ub;
  assign mr   = ua % ub;
  assign uq   = a / b_nz;
  assign ur   = a % b_nz;

  always_comb begin
    hi_res      = 32'd0;
    lo_res      = 32'd0;
    div_by_zero = md_is_div(op) && (b == 32'd0);
    unique case (op)
      MD_MULT:  {hi_res, lo_res} = sprod;
      MD_MULTU: {hi_res, lo_res} = uprod;
      MD_DIV: begin
        lo_res = (a[31] ^ b[31]) ? (~mq + 32'd1) : mq;
        hi_res = a[31] ? (~mr + 32'd1) : mr;
      end
      MD_DIVU: begin
        lo_res = uq;
        hi_res = ur;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, models latency with a
// down-counter and raises md_stall while an op is starting or running.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        E_mf_sel,
  output logic [31:0] md_out,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        start;
  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        div_by_zero;

  assign start    = md_is_start(E_md_op);
  assign busy     = (state == S_BUSY);
  assign md_stall = start | busy;
  assign md_out   = (E_mf_sel == MD_SEL_HI) ? hi : lo;

  md_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      op_q  <= MD_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else if (state == S_IDLE) begin
      if (start) begin
        state <= S_BUSY;
        op_q  <= E_md_op;
        a_q   <= E_rs_val;
        b_q   <= E_rt_val;
        cnt   <= md_is_div(E_md_op) ? 4'(DIV_CYCLES)
                                    : 4'(MULT_CYCLES);
      end else if (E_md_op == MD_MTHI) begin
        hi <= E_rs_val;
      end else if (E_md_op == MD_MTLO) begin
        lo <= E_rs_val;
      end
    end else begin
      // last busy cycle: commit results (skipped for divide by zero)
      if (cnt == 4'd1) begin
        state <= S_IDLE;
        cnt   <= 4'd0;
        if (!div_by_zero) begin
          hi <= hi_res;
          lo <= lo_res;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule
